regfile_writeback: RTL and testbench

- Write-side companion of the GPR file: merges ALU results and load-unit responses onto the single register-file write port (a3/we3/wd3).
- Keeps a per-register busy scoreboard for outstanding loads, so decode can detect RAW/WAW hazards.
- Sits between the execute/memory stages and the register file. It is the only driver of the register file's write port.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/regfile_writeback_if.sv | 56 +++++
 rtl/sync_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 131 +++++++++++++
 tb/tb_regfile_writeback.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register address/data widths, the write-back entry
// layout, and the write-port source encoding.
package cpu_types_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // Which producer owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_t;
endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the write-back block's producer, scoreboard and register-file
// signals. slave = write-back block, master = its surroundings.
interface regfile_writeback_if
    import cpu_types_pkg::*;
#(
    parameter int WIDTH          = XLEN,
    parameter int ADDRESS_LENGTH = REG_ADDR_W
);
    // Handshakes: a load response transfers on a clock edge where ld_valid and
    // ld_ready are both high; ld_ready never depends on ld_valid. An ALU
    // result transfers when alu_valid is high and alu_stall is low, otherwise
    // the producer holds it. An issue is recorded when issue_valid and
    // issue_ready are both high.
    logic                      alu_valid;
    logic [ADDRESS_LENGTH-1:0] alu_rd;
    logic [WIDTH-1:0]          alu_data;
    logic                      alu_stall;

    logic                      ld_valid;
    logic                      ld_ready;
    logic [ADDRESS_LENGTH-1:0] ld_rd;
    logic [WIDTH-1:0]          ld_data;

    logic                      issue_valid;
    logic [ADDRESS_LENGTH-1:0] issue_rd;
    logic                      issue_ready;

    logic [ADDRESS_LENGTH-1:0] q1_addr;
    logic [ADDRESS_LENGTH-1:0] q2_addr;
    logic                      q1_busy;
    logic                      q2_busy;

    logic [ADDRESS_LENGTH-1:0] rf_a3;
    logic                      rf_we3;
    logic [WIDTH-1:0]          rf_wd3;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd,
        input  q1_addr, q2_addr,
        output alu_stall, ld_ready, issue_ready,
        output q1_busy, q2_busy,
        output rf_a3, rf_we3, rf_wd3
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd,
        output q1_addr, q2_addr,
        input  alu_stall, ld_ready, issue_ready,
        input  q1_busy, q2_busy,
        input  rf_a3, rf_we3, rf_wd3
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags. Push when full and pop when empty
// are ignored; the head entry is presented combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Sole driver of the register-file write port: arbitrates ALU results against
// buffered load responses and tracks registers with outstanding loads.
module regfile_writeback
    import cpu_types_pkg::*;
#(
    parameter int WIDTH          = XLEN,
    parameter int ADDRESS_LENGTH = REG_ADDR_W,
    parameter int FIFO_DEPTH     = 2
) (
    input logic              clk,
    input logic              rst,
    regfile_writeback_if.slave wb
);
    localparam int ENTRY_W = ADDRESS_LENGTH + WIDTH;
    localparam int NREG    = 2 ** ADDRESS_LENGTH;

    logic [ENTRY_W-1:0]        fifo_wdata;
    logic [ENTRY_W-1:0]        fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [ADDRESS_LENGTH-1:0] head_rd;
    logic [WIDTH-1:0]          head_data;

    wb_src_t                   sel;
    logic [ADDRESS_LENGTH-1:0] sel_rd;
    logic [WIDTH-1:0]          sel_data;
    logic                      sel_write;

    logic                      rf_we3_q;
    logic [ADDRESS_LENGTH-1:0] rf_a3_q;
    logic [WIDTH-1:0]          rf_wd3_q;
    logic                      src_fifo_q;

    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_next;
    logic                      issue_ok;

    assign fifo_wdata = {wb.ld_rd, wb.ld_data};
    assign fifo_push  = wb.ld_valid && !fifo_full;
    assign fifo_pop   = (sel == SRC_FIFO);
    assign head_rd    = fifo_rdata[ENTRY_W-1 -: ADDRESS_LENGTH];
    assign head_data  = fifo_rdata[WIDTH-1:0];

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_ld_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // A full FIFO takes priority so load responses can always drain
    always_comb begin
        sel          = SRC_NONE;
        wb.alu_stall = 1'b0;
        if (fifo_full) begin
            sel          = SRC_FIFO;
            wb.alu_stall = wb.alu_valid;
        end else if (wb.alu_valid) begin
            sel = SRC_ALU;
        end else if (!fifo_empty) begin
            sel = SRC_FIFO;
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (sel)
            SRC_ALU: begin
                sel_rd   = wb.alu_rd;
                sel_data = wb.alu_data;
            end
            SRC_FIFO: begin
                sel_rd   = head_rd;
                sel_data = head_data;
            end
            default: ;
        endcase
    end

    // x0 winners are consumed without producing a write
    assign sel_write = (sel != SRC_NONE) && (sel_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we3_q   <= 1'b0;
            rf_a3_q    <= '0;
            rf_wd3_q   <= '0;
            src_fifo_q <= 1'b0;
        end else begin
            rf_we3_q   <= sel_write;
            src_fifo_q <= (sel == SRC_FIFO);
            if (sel_write) begin
                rf_a3_q  <= sel_rd;
                rf_wd3_q <= sel_data;
            end
        end
    end

    assign issue_ok = wb.issue_valid && wb.issue_ready;

    // Clear from the completing load write first, so a same-cycle issue wins
    always_comb begin
        busy_next = busy;
        if (rf_we3_q && src_fifo_q) busy_next[rf_a3_q] = 1'b0;
        if (issue_ok) busy_next[wb.issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

    assign wb.ld_ready    = !fifo_full;
    assign wb.issue_ready = !busy[wb.issue_rd];
    assign wb.q1_busy     = busy[wb.q1_addr];
    assign wb.q2_busy     = busy[wb.q2_addr];
    assign wb.rf_we3      = rf_we3_q;
    assign wb.rf_a3       = rf_a3_q;
    assign wb.rf_wd3      = rf_wd3_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a queue/array model of the write-back
// rules is compared every cycle, plus hand-computed spot checks per scenario.
module tb_regfile_writeback;
    import cpu_types_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if bus ();

    regfile_writeback #(
        .WIDTH         (XLEN),
        .ADDRESS_LENGTH(REG_ADDR_W),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb (bus.slave)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    wb_entry_t       fq[$];
    bit [31:0]       busy_m;
    bit              m_we;
    logic [4:0]      m_a3;
    logic [31:0]     m_wd;
    bit              m_src_fifo;
    bit              mf_full;
    bit              mf_ok;
    bit              mf_have;
    wb_entry_t       mf_e;
    wb_entry_t       mf_in;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            busy_m     = '0;
            m_we       = 1'b0;
            m_a3       = '0;
            m_wd       = '0;
            m_src_fifo = 1'b0;
        end else begin
            mf_full = (fq.size() == DEPTH);
            mf_ok   = bus.issue_valid && (bus.issue_rd == 0 || !busy_m[bus.issue_rd]);
            if (m_we && m_src_fifo) busy_m[m_a3] = 1'b0;
            if (mf_ok && bus.issue_rd != 0) busy_m[bus.issue_rd] = 1'b1;
            mf_have = 1'b0;
            if (mf_full || (!bus.alu_valid && fq.size() > 0)) begin
                mf_e       = fq.pop_front();
                mf_have    = 1'b1;
                m_src_fifo = 1'b1;
            end else if (bus.alu_valid) begin
                mf_e.rd    = bus.alu_rd;
                mf_e.data  = bus.alu_data;
                mf_have    = 1'b1;
                m_src_fifo = 1'b0;
            end else begin
                m_src_fifo = 1'b0;
            end
            m_we = mf_have && (mf_e.rd != 0);
            if (m_we) begin
                m_a3 = mf_e.rd;
                m_wd = mf_e.data;
            end
            if (bus.ld_valid && !mf_full) begin
                mf_in.rd   = bus.ld_rd;
                mf_in.data = bus.ld_data;
                fq.push_back(mf_in);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge rst);
        forever begin
            @(negedge clk);
            #2;
            chk("ld_ready", bus.ld_ready, fq.size() < DEPTH);
            chk("alu_stall", bus.alu_stall, bus.alu_valid && fq.size() == DEPTH);
            chk("issue_ready", bus.issue_ready, bus.issue_rd == 0 || !busy_m[bus.issue_rd]);
            chk("q1_busy", bus.q1_busy, busy_m[bus.q1_addr]);
            chk("q2_busy", bus.q2_busy, busy_m[bus.q2_addr]);
            chk("rf_we3", bus.rf_we3, m_we);
            if (m_we) begin
                chk("rf_a3", bus.rf_a3, m_a3);
                chk("rf_wd3", bus.rf_wd3, m_wd);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic set_idle();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd7;
    endtask

    task automatic step();
        @(negedge clk);
        set_idle();
    endtask

    int ai;
    int li;
    int cyc;

    initial begin
        set_idle();
        bus.q1_addr = '0;
        bus.q2_addr = '0;
        #1 rst = 1'b1;
        step();
        step();
        #3;
        chk("rst_we3", bus.rf_we3, 1'b0);
        chk("rst_a3", bus.rf_a3, 5'd0);
        chk("rst_wd3", bus.rf_wd3, 32'd0);
        chk("rst_ld_ready", bus.ld_ready, 1'b1);
        chk("rst_issue_ready", bus.issue_ready, 1'b1);
        step();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            step();
            bus.q1_addr = 5'(i);
            bus.q2_addr = 5'(31 - i);
            #3 chk("idle_q1_busy", bus.q1_busy, 1'b0);
        end

        // ALU alone
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #3 chk("alu_stall_lone", bus.alu_stall, 1'b0);
        step();
        #3;
        chk("alu_we3", bus.rf_we3, 1'b1);
        chk("alu_a3", bus.rf_a3, 5'd5);
        chk("alu_wd3", bus.rf_wd3, 32'hDEADBEEF);
        step();
        #3 chk("alu_idle_we3", bus.rf_we3, 1'b0);

        // Load lifecycle for x7
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.q1_addr = 5'd7;
        #3 chk("ld7_issue_ready", bus.issue_ready, 1'b1);
        step();
        #3;
        chk("ld7_busy_set", bus.q1_busy, 1'b1);
        chk("ld7_issue_blocked", bus.issue_ready, 1'b0);
        step();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h1234;
        step();
        step();
        #3;
        chk("ld7_we3", bus.rf_we3, 1'b1);
        chk("ld7_a3", bus.rf_a3, 5'd7);
        chk("ld7_wd3", bus.rf_wd3, 32'h1234);
        chk("ld7_busy_during_write", bus.q1_busy, 1'b1);
        step();
        #3 chk("ld7_busy_cleared", bus.q1_busy, 1'b0);

        // Priority / fill: ALU held while three loads arrive
        ai = 0; li = 0; cyc = 0;
        while ((ai < 4 || li < 3) && cyc < 40) begin
            step();
            if (ai < 4) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd    = 5'(10 + ai);
                bus.alu_data  = 32'hA000_0000 + 32'(ai);
            end
            if (li < 3) begin
                bus.ld_valid = 1'b1;
                bus.ld_rd    = 5'(20 + li);
                bus.ld_data  = 32'h5000_0000 + 32'(li);
            end
            #3;
            if (cyc == 2) begin
                chk("fill_alu_stall", bus.alu_stall, 1'b1);
                chk("fill_ld_ready", bus.ld_ready, 1'b0);
            end
            if (cyc == 3) begin
                chk("fill_head_we3", bus.rf_we3, 1'b1);
                chk("fill_head_a3", bus.rf_a3, 5'd20);
                chk("fill_head_wd3", bus.rf_wd3, 32'h5000_0000);
            end
            #1;
            if (bus.alu_valid && !bus.alu_stall) ai++;
            if (bus.ld_valid && bus.ld_ready) li++;
            cyc++;
        end
        chk("fill_all_accepted", {30'd0, ai == 4, li == 3}, 2'b11);
        chk("fill_cycles", cyc, 6);
        repeat (3) step();

        // x0 handling
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h11;
        #3 chk("x0_alu_stall", bus.alu_stall, 1'b0);
        step();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h22;
        #3 chk("x0_alu_no_write", bus.rf_we3, 1'b0);
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.q1_addr = 5'd0;
        #3 chk("x0_issue_ready", bus.issue_ready, 1'b1);
        step();
        #3;
        chk("x0_ld_no_write", bus.rf_we3, 1'b0);
        chk("x0_not_busy", bus.q1_busy, 1'b0);

        // Same-cycle set and clear of x3
        step();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h33;
        step();
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; bus.q1_addr = 5'd3;
        #3;
        chk("setclr_we3", bus.rf_we3, 1'b1);
        chk("setclr_a3", bus.rf_a3, 5'd3);
        chk("setclr_issue_ready", bus.issue_ready, 1'b1);
        step();
        #3 chk("setclr_busy3_kept", bus.q1_busy, 1'b1);

        // Async reset in the middle of a load burst
        step();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd20; bus.ld_data = 32'h200;
        step();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd21; bus.ld_data = 32'h210;
        bus.q1_addr = 5'd9; bus.q2_addr = 5'd3;
        step();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd22; bus.ld_data = 32'h220;
        #3;
        chk("burst_pre_we3", bus.rf_we3, 1'b1);
        chk("burst_pre_busy9", bus.q1_busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("burst_rst_we3", bus.rf_we3, 1'b0);
        chk("burst_rst_ld_ready", bus.ld_ready, 1'b1);
        chk("burst_rst_busy9", bus.q1_busy, 1'b0);
        chk("burst_rst_busy3", bus.q2_busy, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h55;
        step();
        #3;
        chk("post_rst_we3", bus.rf_we3, 1'b1);
        chk("post_rst_a3", bus.rf_a3, 5'd1);
        chk("post_rst_wd3", bus.rf_wd3, 32'h55);
        repeat (2) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
